// File: rtl/vga_pkg.sv
// Shared types for the VRAM arbiter: CPU-side FSM state encoding and return-tag owner codes.
package vga_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CPU_WR  = 3'd1,
        CPU_RD  = 3'd2,
        WAIT_RD = 3'd3,
        ACK     = 3'd4
    } state_t;

    typedef enum logic {
        OWN_PIX = 1'b0,
        OWN_CPU = 1'b1
    } owner_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundles the scanout, CPU and VRAM-macro signals of the arbiter.
// The arbiter uses the slave view; the surrounding system (VGA, CPU, RAM) uses the master view.
interface vram_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
);
    logic              hblank;
    logic              vblank;
    logic              pix_req;
    logic [ADDR_W-1:0] pix_addr;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              pix_miss;

    modport slave (
        input  hblank, vblank, pix_req, pix_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output pix_data, pix_valid, cpu_rdata, cpu_ack,
        output mem_addr, mem_en, mem_we, mem_wdata, pix_miss
    );

    modport master (
        output hblank, vblank, pix_req, pix_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  pix_data, pix_valid, cpu_rdata, cpu_ack,
        input  mem_addr, mem_en, mem_we, mem_wdata, pix_miss
    );
endinterface

// File: rtl/rd_tag_pipe.sv
// RD_LAT-deep {valid, owner} shift register fed from the registered VRAM command; its tail lines
// up with mem_rdata, so ret_pix_o/ret_cpu_o strobe exactly when the matching read word is present.
module rd_tag_pipe
    import vga_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   vld_i,
    input  owner_t own_i,
    output logic   ret_pix_o,
    output logic   ret_cpu_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] cpu_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            cpu_q <= '0;
        end else begin
            vld_q[0] <= vld_i;
            cpu_q[0] <= (own_i == OWN_CPU);
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                cpu_q[i] <= cpu_q[i-1];
            end
        end
    end

    assign ret_pix_o = vld_q[RD_LAT-1] & ~cpu_q[RD_LAT-1];
    assign ret_cpu_o = vld_q[RD_LAT-1] &  cpu_q[RD_LAT-1];

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout always wins, CPU fills idle slots; mem_* registered (1 cycle).
// Pixel data returns RD_LAT+1 after pix_req; a CPU request is held off (no ack) while pixels win.
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic         clock,
    input  logic         reset,
    vram_arbiter_if.slave bus
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    owner_t            own_q, own_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              pix_miss_q, pix_miss_d;
    logic              cpu_grant;
    logic              ret_pix;
    logic              ret_cpu;

    // The CPU slot is only granted from IDLE and only when scanout leaves the slot free;
    // otherwise the held cpu_req is simply looked at again next cycle.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        own_d       = own_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_grant   = bus.cpu_req && !bus.pix_req && (state_q == IDLE);

        if (bus.pix_req) begin
            mem_addr_d = bus.pix_addr;
            mem_en_d   = 1'b1;
            own_d      = OWN_PIX;
        end else if (cpu_grant) begin
            mem_addr_d = bus.cpu_addr;
            mem_en_d   = 1'b1;
            mem_we_d   = bus.cpu_we;
            own_d      = OWN_CPU;
            if (bus.cpu_we) begin
                mem_wdata_d = bus.cpu_wdata;
            end
        end

        case (state_q)
            IDLE:    if (cpu_grant) state_d = bus.cpu_we ? CPU_WR : CPU_RD;
            CPU_WR:  state_d = ACK;
            CPU_RD:  state_d = WAIT_RD;
            WAIT_RD: begin
                if (ret_cpu) begin
                    cpu_rdata_d = bus.mem_rdata;
                    state_d     = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A scanout fetch colliding with a CPU write during active video means the schedule is broken.
        pix_miss_d = pix_miss_q |
                     (bus.pix_req & ~bus.hblank & ~bus.vblank & mem_en_q & mem_we_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            own_q       <= OWN_PIX;
            cpu_rdata_q <= '0;
            pix_miss_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            own_q       <= own_d;
            cpu_rdata_q <= cpu_rdata_d;
            pix_miss_q  <= pix_miss_d;
        end
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clock     (clock),
        .reset     (reset),
        .vld_i     (mem_en_q & ~mem_we_q),
        .own_i     (own_q),
        .ret_pix_o (ret_pix),
        .ret_cpu_o (ret_cpu)
    );

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.pix_valid = ret_pix;
    assign bus.pix_data  = ret_pix ? bus.mem_rdata : '0;
    assign bus.cpu_ack   = (state_q == ACK);
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.pix_miss  = pix_miss_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a 2-cycle-latency VRAM model and hand-derived expectations.
module tb_vram_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    typedef struct {
        int         cyc;
        logic [7:0] d;
    } ev_t;

    ev_t pix_q[$];
    ev_t ack_q[$];

    vram_arbiter_if #(.ADDR_W(15), .DATA_W(8)) bus ();

    vram_arbiter #(
        .ADDR_W (15),
        .DATA_W (8),
        .RD_LAT (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // VRAM content: low byte ^ high bits ^ 0x5A, e.g. 0x0010 -> 0x4A, 0x0300 -> 0x59, 0x0500 -> 0x5F.
    function automatic logic [7:0] pat(input logic [14:0] a);
        return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5A;
    endfunction

    logic [7:0] mem [0:32767];
    logic [7:0] rd_p0 = '0;
    logic [7:0] rd_p1 = '0;

    initial begin
        for (int a = 0; a < 32768; a++) mem[a] = pat(15'(a));
    end

    always @(posedge clock) begin
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        rd_p0 <= mem[bus.mem_addr];
        rd_p1 <= rd_p0;
    end
    assign bus.mem_rdata = rd_p1;

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.pix_valid) pix_q.push_back('{cyc, bus.pix_data});
            if (bus.cpu_ack)   ack_q.push_back('{cyc, bus.cpu_rdata});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cpu_access(input logic we, input logic [14:0] a, input logic [7:0] d,
                              output logic [7:0] rd, output int lat);
        int n = 0;
        bit seen = 1'b0;
        tick();
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        rd  = '0;
        lat = -1;
        while (!seen && n < 100) begin
            @(negedge clock);
            if (bus.cpu_ack) begin
                seen = 1'b1;
                rd   = bus.cpu_rdata;
                lat  = n;
            end else begin
                tick();
                n++;
            end
        end
        tick();
        bus.cpu_req = 1'b0;
        check("cpu_ack_seen", 32'(seen), 32'd1);
    endtask

    task automatic pix_burst(input logic [14:0] base, input int n, output int start);
        start = -1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == 0) start = cyc;
            bus.pix_req  = 1'b1;
            bus.pix_addr = base + 15'(i);
        end
        tick();
        bus.pix_req = 1'b0;
    endtask

    task automatic check_pix(input string tag, input logic [14:0] base, input int n, input int start);
        check({tag, "_cnt"}, 32'(pix_q.size()), 32'(n));
        for (int i = 0; i < n && i < pix_q.size(); i++) begin
            check({tag, "_cyc"}, 32'(pix_q[i].cyc), 32'(start + 3 + i));
            check({tag, "_dat"}, 32'(pix_q[i].d), 32'(pat(base + 15'(i))));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        int lat, s, s2;

        bus.hblank = 1'b0; bus.vblank = 1'b0;
        bus.pix_req = 1'b0; bus.pix_addr = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        repeat (3) tick();
        reset = 1'b0;

        // 1: idle after reset, every output stays zero
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("reset_idle",
                  {bus.pix_data, bus.pix_valid, bus.cpu_rdata, bus.cpu_ack, bus.pix_miss,
                   bus.mem_en, bus.mem_we},
                  32'd0);
            check("reset_mem_bus", {bus.mem_addr, bus.mem_wdata}, 32'd0);
        end

        // 2: single pixel read at 0x0010
        tick(); bus.pix_req = 1'b1; bus.pix_addr = 15'h0010;
        tick(); bus.pix_req = 1'b0;
        @(negedge clock);
        check("pix_mem_en",   32'(bus.mem_en),   32'd1);
        check("pix_mem_we",   32'(bus.mem_we),   32'd0);
        check("pix_mem_addr", 32'(bus.mem_addr), 32'h0010);
        tick(); @(negedge clock);
        check("pix_valid_early", 32'(bus.pix_valid), 32'd0);
        tick(); @(negedge clock);
        check("pix_valid_lat", 32'(bus.pix_valid), 32'd1);
        check("pix_data",      32'(bus.pix_data),  32'h4A);
        tick(); @(negedge clock);
        check("pix_valid_pulse", 32'(bus.pix_valid), 32'd0);

        // 3: CPU write in blanking, then readback
        bus.vblank = 1'b1;
        tick();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 15'h1234; bus.cpu_wdata = 8'hA5;
        tick(); @(negedge clock);
        check("wr_mem_en",    32'(bus.mem_en),    32'd1);
        check("wr_mem_we",    32'(bus.mem_we),    32'd1);
        check("wr_mem_addr",  32'(bus.mem_addr),  32'h1234);
        check("wr_mem_wdata", 32'(bus.mem_wdata), 32'hA5);
        check("wr_ack_early", 32'(bus.cpu_ack),   32'd0);
        tick(); @(negedge clock);
        check("wr_ack", 32'(bus.cpu_ack), 32'd1);
        tick(); bus.cpu_req = 1'b0;
        cpu_access(1'b0, 15'h1234, 8'h00, rd, lat);
        check("rd_back_data", 32'(rd), 32'hA5);
        check("rd_back_lat",  32'(lat), 32'd4);
        bus.vblank = 1'b0;

        // 4: CPU write held against 8 back-to-back pixel reads
        repeat (4) tick();
        pix_q.delete(); ack_q.delete();
        fork
            cpu_access(1'b1, 15'h0200, 8'h3C, rd, lat);
            pix_burst(15'h0100, 8, s);
        join
        repeat (5) tick();
        check("cont_cpu_lat", 32'(lat), 32'd10);
        check("cont_ack_cnt", 32'(ack_q.size()), 32'd1);
        check_pix("cont_pix", 15'h0100, 8, s);
        check("cont_no_miss", 32'(bus.pix_miss), 32'd0);
        cpu_access(1'b0, 15'h0200, 8'h00, rd, lat);
        check("cont_rd_back", 32'(rd), 32'h3C);

        // 5: CPU read waiting for its data while pixel reads stream past it
        repeat (3) tick();
        pix_q.delete();
        fork
            cpu_access(1'b0, 15'h0300, 8'h00, rd, lat);
            begin
                tick();
                pix_burst(15'h0400, 4, s2);
            end
        join
        repeat (5) tick();
        check("intl_cpu_data", 32'(rd),  32'h59);
        check("intl_cpu_lat",  32'(lat), 32'd4);
        check_pix("intl_pix", 15'h0400, 4, s2);

        // pix_miss: scanout fetch while a CPU write sits on the bus in active video
        tick();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 15'h0700; bus.cpu_wdata = 8'h77;
        tick(); bus.pix_req = 1'b1; bus.pix_addr = 15'h0010;
        @(negedge clock);
        check("miss_before", 32'(bus.pix_miss), 32'd0);
        tick(); bus.pix_req = 1'b0;
        @(negedge clock);
        check("miss_set", 32'(bus.pix_miss), 32'd1);
        check("miss_wr_ack", 32'(bus.cpu_ack), 32'd1);
        tick(); bus.cpu_req = 1'b0;
        repeat (4) tick();
        @(negedge clock);
        check("miss_sticky", 32'(bus.pix_miss), 32'd1);

        // 6: async reset while a CPU read and a pixel read are in flight
        tick();
        pix_q.delete(); ack_q.delete();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 15'h0500;
        tick(); bus.pix_req = 1'b1; bus.pix_addr = 15'h0600;
        tick(); bus.pix_req = 1'b0; bus.cpu_req = 1'b0;
        #2 reset = 1'b1;
        @(negedge clock);
        check("rst_mem_en",   32'(bus.mem_en),   32'd0);
        check("rst_cpu_ack",  32'(bus.cpu_ack),  32'd0);
        check("rst_pix_miss", 32'(bus.pix_miss), 32'd0);
        tick(); tick();
        reset = 1'b0;
        repeat (8) tick();
        check("rst_no_pix", 32'(pix_q.size()), 32'd0);
        check("rst_no_ack", 32'(ack_q.size()), 32'd0);
        cpu_access(1'b0, 15'h0500, 8'h00, rd, lat);
        check("rst_next_data", 32'(rd),  32'h5F);
        check("rst_next_lat",  32'(lat), 32'd4);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
